// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the UART transmit byte buffer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_tx_fifo_pkg;

  // Default geometry: 16 entries, 4-bit pointers.
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int BYTE_W         = 8;

  // Launch sequencer states. Encodings are fixed so they read the same in
  // waveforms across every block that decodes them.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } tx_state_t;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the CPU write side and transmitter handshake around the byte buffer.
// Latency: n/a (wiring only).
// Backpressure: writer watches o_Full; launcher waits on TX Active/Done.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  // CPU write side
  logic          i_Wr_DV;
  byte_t         i_Wr_Byte;
  logic          o_Full;
  logic          o_Empty;
  logic [ADDR_W:0] o_Count;
  logic          o_Overflow;
  logic          i_Ovf_Clr;

  // Transmitter side
  logic          o_TX_DV;
  byte_t         o_TX_Byte;
  logic          i_TX_Active;
  logic          i_TX_Done;
  logic          o_Busy;

  // The buffer itself
  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Ovf_Clr, i_TX_Active, i_TX_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte, o_Busy
  );

  // The environment: CPU writer plus transmitter
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Ovf_Clr, i_TX_Active, i_TX_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte, o_Busy
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy count and registered flags.
// Latency: push visible in count/empty on the next cycle; head readable combinationally.
// Backpressure: push ignored when full, pop ignored when empty (flags are pre-edge).
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int WIDTH  = BYTE_W
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Push,
  input  logic [WIDTH-1:0]  i_Push_Data,
  input  logic              i_Pop,
  output logic [WIDTH-1:0]  o_Pop_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count
);

  localparam logic [ADDR_W:0] LP_FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE = ADDR_W'(1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [ADDR_W:0]   w_count_nxt;

  // Full/empty are judged on the registered (pre-edge) flags, so a pop in the
  // same cycle never frees a slot for a write arriving while full.
  assign w_push_ok = i_Push && !r_full;
  assign w_pop_ok  = i_Pop  && !r_empty;

  // Next occupancy: push and pop together leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + LP_CNT_ONE;
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - LP_CNT_ONE;
    end
  end

  // Storage write; the array is deliberately left out of reset.
  always_ff @(posedge i_Clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_Push_Data;
    end
  end

  // Pointer advance; power-of-two depth lets them wrap naturally.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
    end
  end

  // Occupancy and flags, all registered from the same next-count value.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_Pop_Data = r_mem[r_rd_ptr];
  assign o_Full     = r_full;
  assign o_Empty    = r_empty;
  assign o_Count    = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter: queues CPU writes, launches them one at a time.
// Latency: write to o_TX_DV is 2 cycles when buffer empty and transmitter idle.
// Backpressure: writes dropped (sticky o_Overflow) when full; launch waits for TX Active/Done low.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  uart_tx_fifo_if.slave    io_Bus
);

  tx_state_t       r_state;
  logic            r_tx_dv;
  byte_t           r_tx_byte;
  logic            r_overflow;

  logic            w_full;
  logic            w_empty;
  logic [ADDR_W:0] w_count;
  byte_t           w_head;
  logic            w_push;
  logic            w_drop;
  logic            w_launch;

  // A write while full is lost; the FIFO's registered full flag makes this a
  // pre-edge decision even when the launcher pops in the same cycle.
  assign w_push = io_Bus.i_Wr_DV && !w_full;
  assign w_drop = io_Bus.i_Wr_DV &&  w_full;

  // Launch only from IDLE with data waiting and the transmitter fully quiet.
  // Checking Done as well as Active swallows the two-cycle Done tail, and
  // after a reset it holds off until an orphaned frame has finished.
  assign w_launch = (r_state == ST_IDLE) && !w_empty &&
                    !io_Bus.i_TX_Active && !io_Bus.i_TX_Done;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (BYTE_W)
  ) u_fifo (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Push      (w_push),
    .i_Push_Data (io_Bus.i_Wr_Byte),
    .i_Pop       (w_launch),
    .o_Pop_Data  (w_head),
    .o_Full      (w_full),
    .o_Empty     (w_empty),
    .o_Count     (w_count)
  );

  // Launch sequencer: pops the head into the output byte register with a
  // one-cycle DV pulse, then tracks the transmitter through start and done.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state   <= ST_IDLE;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx_dv <= 1'b0;
          if (w_launch) begin
            r_tx_byte <= w_head;
            r_tx_dv   <= 1'b1;
            r_state   <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          r_tx_dv <= 1'b0;
          if (io_Bus.i_TX_Active) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          r_tx_dv <= 1'b0;
          if (io_Bus.i_TX_Done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx_dv <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; an explicit clear beats a drop in the same cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_overflow <= 1'b0;
    end else if (io_Bus.i_Ovf_Clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign io_Bus.o_Full     = w_full;
  assign io_Bus.o_Empty    = w_empty;
  assign io_Bus.o_Count    = w_count;
  assign io_Bus.o_Overflow = r_overflow;
  assign io_Bus.o_TX_DV    = r_tx_dv;
  assign io_Bus.o_TX_Byte  = r_tx_byte;
  assign io_Bus.o_Busy     = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for the UART transmit byte buffer, with a behavioural transmitter (4 clocks per bit).
// Checks launches against a queue-based model of accepted bytes every cycle.
// Scenario tasks add directed checks on latency, full/overflow, reset and busy.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CPB    = 4;
  localparam int DRAIN_BUDGET = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .io_Bus  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural transmitter (no reset, like the real one) ----
  int         tx_phase = 0;   // 0 idle, 1 sending frame, 2 done tail
  int         tx_tick  = 0;
  logic       tx_active = 1'b0;
  logic       tx_done   = 1'b0;
  logic       tx_stall  = 1'b0;   // makes the transmitter look busy
  logic [9:0] tx_frame  = '1;
  logic [9:0] rx_frame  = '0;
  logic       tx_serial;

  assign tx_serial       = (tx_phase == 1) ? tx_frame[tx_tick/CPB] : 1'b1;
  assign bus.i_TX_Active = tx_active | tx_stall;
  assign bus.i_TX_Done   = tx_done;

  always @(posedge clk) begin
    case (tx_phase)
      0: if (bus.o_TX_DV === 1'b1) begin
           tx_frame  <= {1'b1, bus.o_TX_Byte, 1'b0};
           tx_active <= 1'b1;
           tx_tick   <= 0;
           tx_phase  <= 1;
         end
      1: begin
           if (tx_tick % CPB == CPB/2) rx_frame[tx_tick/CPB] <= tx_serial;
           if (tx_tick == 10*CPB-1) begin
             tx_active <= 1'b0;
             tx_done   <= 1'b1;
             tx_tick   <= 0;
             tx_phase  <= 2;
           end else begin
             tx_tick <= tx_tick + 1;
           end
         end
      default: if (tx_tick == 1) begin
                 tx_done  <= 1'b0;
                 tx_tick  <= 0;
                 tx_phase <= 0;
               end else begin
                 tx_tick <= tx_tick + 1;
               end
    endcase
  end

  // ---------------- reference model: queue of accepted bytes ----------------
  logic [7:0] exp_q[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       pend_acc = 1'b0, pend_drop = 1'b0, pend_clr = 1'b0;
  logic [7:0] pend_byte = '0;
  logic       prev_dv = 1'b0, prev_act = 1'b0, prev_done = 1'b0;
  int         n_launch = 0;
  logic [7:0] last_byte = '0;

  task automatic monitor_loop();
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_count = 0; m_ovf = 1'b0; exp_q.delete();
        pend_acc = 1'b0; pend_drop = 1'b0; pend_clr = 1'b0;
        prev_dv = 1'b0;
      end else begin
        // apply what the last edge did
        if (pend_acc) begin exp_q.push_back(pend_byte); m_count++; end
        if (pend_clr) m_ovf = 1'b0;
        else if (pend_drop) m_ovf = 1'b1;
        pend_acc = 1'b0; pend_drop = 1'b0; pend_clr = 1'b0;
        if (bus.o_TX_DV === 1'b1) begin
          n_launch++;
          last_byte = bus.o_TX_Byte;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL launch_order: got byte %02h, required no launch (nothing queued)", bus.o_TX_Byte);
          end else begin
            exp_b = exp_q.pop_front();
            m_count--;
            if (bus.o_TX_Byte !== exp_b) begin
              n_err++;
              $display("FAIL launch_order: got byte %02h, required %02h", bus.o_TX_Byte, exp_b);
            end
          end
          n_vec++;
          if (prev_dv) begin
            n_err++;
            $display("FAIL dv_width: DV high two cycles in a row, required one-cycle pulse");
          end
          n_vec++;
          if (prev_act || prev_done) begin
            n_err++;
            $display("FAIL dv_while_busy: launched with active=%0b done=%0b, required both 0", prev_act, prev_done);
          end
        end
        n_vec++;
        if (bus.o_Count !== (ADDR_W+1)'(m_count)) begin
          n_err++;
          $display("FAIL count: got %0d, required %0d", bus.o_Count, m_count);
        end
        n_vec++;
        if (bus.o_Full !== (m_count == DEPTH) || bus.o_Empty !== (m_count == 0)) begin
          n_err++;
          $display("FAIL flags: got full=%0b empty=%0b, required full=%0b empty=%0b",
                   bus.o_Full, bus.o_Empty, (m_count == DEPTH), (m_count == 0));
        end
        n_vec++;
        if (bus.o_Overflow !== m_ovf) begin
          n_err++;
          $display("FAIL overflow: got %0b, required %0b", bus.o_Overflow, m_ovf);
        end
        // decide what the coming edge does, from pre-edge occupancy
        if (bus.i_Wr_DV) begin
          if (m_count < DEPTH) begin pend_acc = 1'b1; pend_byte = bus.i_Wr_Byte; end
          else pend_drop = 1'b1;
        end
        pend_clr = bus.i_Ovf_Clr;
        prev_dv  = bus.o_TX_DV;
      end
      prev_act  = bus.i_TX_Active;
      prev_done = bus.i_TX_Done;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = b;
    cyc();
    bus.i_Wr_DV = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (!(bus.o_Busy === 1'b0 && tx_phase == 0) && k < DRAIN_BUDGET) begin
      cyc(); k++;
    end
    n_vec++;
    if (k >= DRAIN_BUDGET) begin
      n_err++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", tag, k);
    end
  endtask

  task automatic fill_stalled(input logic [7:0] base, input int rnd);
    tx_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rnd != 0) write_byte(8'($urandom_range(0, 254)));
      else write_byte(base + 8'(i));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.o_Empty !== 1'b1 || bus.o_Full !== 1'b0 || bus.o_Count !== 5'd0) begin
      n_err++;
      $display("FAIL reset_flags: got empty=%0b full=%0b count=%0d, required 1 0 0", bus.o_Empty, bus.o_Full, bus.o_Count);
    end
    n_vec++;
    if (bus.o_Overflow !== 1'b0 || bus.o_TX_DV !== 1'b0 || bus.o_Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ovf=%0b dv=%0b busy=%0b, required 0 0 0", bus.o_Overflow, bus.o_TX_DV, bus.o_Busy);
    end
    n_vec++;
    if (bus.o_TX_Byte !== 8'h00) begin
      n_err++;
      $display("FAIL reset_byte: got %02h, required 00", bus.o_TX_Byte);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    int k;
    write_byte(8'h41);
    @(negedge clk);
    n_vec++;
    if (bus.o_TX_DV !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency1: DV got %0b one cycle after write, required 0", bus.o_TX_DV);
    end
    @(negedge clk);
    n_vec++;
    if (bus.o_TX_DV !== 1'b1 || bus.o_TX_Byte !== 8'h41) begin
      n_err++;
      $display("FAIL single_latency2: got dv=%0b byte=%02h two cycles after write, required 1 41", bus.o_TX_DV, bus.o_TX_Byte);
    end
    n_vec++;
    if (bus.o_Busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy: got %0b during launch, required 1", bus.o_Busy);
    end
    k = 0;
    while (tx_phase != 2 && k < 200) begin @(negedge clk); k++; end
    while (tx_phase != 0 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    n_vec++;
    if (k >= 200 || bus.o_Busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_drop: got busy=%0b after %0d cycles, required 0 after Done", bus.o_Busy, k);
    end
    n_vec++;
    if (rx_frame !== 10'b1_0100_0001_0) begin
      n_err++;
      $display("FAIL single_serial: got frame %b, required 1010000010", rx_frame);
    end
    cyc();
  endtask

  task automatic test_fill_order();
    int l0;
    fill_stalled(8'h01, 0);
    @(negedge clk);
    n_vec++;
    if (bus.o_Full !== 1'b1 || bus.o_Count !== 5'd16) begin
      n_err++;
      $display("FAIL fill_full: got full=%0b count=%0d, required 1 16", bus.o_Full, bus.o_Count);
    end
    cyc();
    l0 = n_launch;
    tx_stall = 1'b0;
    drain("fill");
    n_vec++;
    if (n_launch - l0 != 16) begin
      n_err++;
      $display("FAIL fill_dv_count: got %0d launches, required 16", n_launch - l0);
    end
  endtask

  task automatic test_overflow();
    int l0;
    fill_stalled(8'h00, 1);
    write_byte(8'hFF);
    @(negedge clk);
    n_vec++;
    if (bus.o_Overflow !== 1'b1 || bus.o_Count !== 5'd16) begin
      n_err++;
      $display("FAIL ovf_set: got ovf=%0b count=%0d, required 1 16", bus.o_Overflow, bus.o_Count);
    end
    cyc();
    bus.i_Ovf_Clr = 1'b1; cyc(); bus.i_Ovf_Clr = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.o_Overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %0b, required 0", bus.o_Overflow);
    end
    cyc();
    bus.i_Ovf_Clr = 1'b1;
    write_byte(8'hFF);
    bus.i_Ovf_Clr = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.o_Overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr_priority: got %0b, required 0", bus.o_Overflow);
    end
    cyc();
    l0 = n_launch;
    tx_stall = 1'b0;
    drain("ovf");
    n_vec++;
    if (n_launch - l0 != 16) begin
      n_err++;
      $display("FAIL ovf_dv_count: got %0d launches, required 16", n_launch - l0);
    end
  endtask

  task automatic test_full_pop_write();
    fill_stalled(8'h00, 1);
    tx_stall = 1'b0;
    write_byte(8'hEE);
    @(negedge clk);
    n_vec++;
    if (bus.o_TX_DV !== 1'b1 || bus.o_Count !== 5'd15 || bus.o_Overflow !== 1'b1) begin
      n_err++;
      $display("FAIL full_pop_write: got dv=%0b count=%0d ovf=%0b, required 1 15 1", bus.o_TX_DV, bus.o_Count, bus.o_Overflow);
    end
    cyc();
    bus.i_Ovf_Clr = 1'b1; cyc(); bus.i_Ovf_Clr = 1'b0;
    drain("fpw");
  endtask

  task automatic test_reset_mid_frame();
    int k, l0;
    for (int i = 0; i < 5; i++) write_byte(8'($urandom_range(0, 255)));
    k = 0;
    while (tx_phase != 1 && k < 50) begin cyc(); k++; end
    repeat (8) cyc();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.o_Empty !== 1'b1 || bus.o_Count !== 5'd0 || bus.o_Busy !== 1'b0 || bus.o_TX_DV !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: got empty=%0b count=%0d busy=%0b dv=%0b, required 1 0 0 0",
               bus.o_Empty, bus.o_Count, bus.o_Busy, bus.o_TX_DV);
    end
    cyc();
    rst_n = 1'b1;
    l0 = n_launch;
    write_byte(8'h55);
    repeat (3) @(negedge clk);
    n_vec++;
    if (n_launch != l0 || tx_phase != 1) begin
      n_err++;
      $display("FAIL rst_guard: got %0d launches while orphan frame active, required 0", n_launch - l0);
    end
    cyc();
    k = 0;
    while (n_launch == l0 && k < 200) begin cyc(); k++; end
    n_vec++;
    if (n_launch == l0 || last_byte !== 8'h55) begin
      n_err++;
      $display("FAIL rst_resume: got launches=%0d byte=%02h, required 1 55", n_launch - l0, last_byte);
    end
    drain("rst");
    n_vec++;
    if (n_launch - l0 != 1) begin
      n_err++;
      $display("FAIL rst_once: got %0d launches after reset, required 1", n_launch - l0);
    end
  endtask

  task automatic test_trickle();
    for (int i = 0; i < 14; i++) begin
      write_byte(8'($urandom_range(0, 255)));
      repeat (6) cyc();
    end
    drain("trickle");
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      bus.i_Wr_DV   = ($urandom_range(0, 99) < 35);
      bus.i_Wr_Byte = 8'($urandom);
      bus.i_Ovf_Clr = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 3) tx_stall = ~tx_stall;
      cyc();
    end
    bus.i_Wr_DV = 1'b0; bus.i_Ovf_Clr = 1'b0; tx_stall = 1'b0;
    drain("random");
  endtask

  initial begin
    bus.i_Wr_DV = 1'b0; bus.i_Wr_Byte = '0; bus.i_Ovf_Clr = 1'b0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_fill_order();
    test_overflow();
    test_full_pop_write();
    test_reset_mid_frame();
    test_trickle();
    test_random();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue: got %0d bytes never launched, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
